// File: rtl/muxn_arb.sv
// rtl/muxn_arb.sv - CH-channel registered mux with direct or round-robin select; optional parity register via MUXN_ARB_PARITY_EN
module muxn_arb #(
  parameter int n  = 32,
  parameter int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MODE,
  input  logic [SW-1:0]   S,
  input  logic [CH*n-1:0] D,
  input  logic [CH-1:0]   V,
  output logic [CH-1:0]   G,
  output logic [n-1:0]    Y,
  output logic            VY,
  output logic [SW-1:0]   SY,
  input  logic            READY,
  output logic            P
);

  logic [n-1:0]  y_q;
  logic [n-1:0]  y_d;
  logic [SW-1:0] sy_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] cand_idx;
  logic          vy_q;
  logic          accept;
  logic          cand_ok;
  logic          load;

  // Channel index reached by stepping 'off' places past p, wrapping at CH (not at 2**SW).
  function automatic int rr_pos(input logic [SW-1:0] p, input int off);
    int t;
    t = int'(p) + off;
    return (t >= CH) ? t - CH : t;
  endfunction

  // The register can take a word when it is empty or its word leaves this cycle.
  assign accept = !vy_q || READY;
  assign load   = !rst && accept && cand_ok;

  // Candidate selection: direct index, or first valid channel after the last grant.
  always_comb begin
    cand_ok  = 1'b0;
    cand_idx = '0;
    if (!MODE) begin
      for (int k = 0; k < CH; k++) begin
        if (int'(S) == k && V[k]) begin
          cand_ok  = 1'b1;
          cand_idx = SW'(k);
        end
      end
    end else begin
      // Walk from farthest to nearest so the nearest valid channel wins.
      for (int i = CH; i >= 1; i--) begin
        if (V[rr_pos(ptr_q, i)]) begin
          cand_ok  = 1'b1;
          cand_idx = SW'(rr_pos(ptr_q, i));
        end
      end
    end
  end

  // Data steering and one-hot grant for the chosen candidate.
  always_comb begin
    G   = '0;
    y_d = '0;
    for (int k = 0; k < CH; k++) begin
      if (cand_idx == SW'(k)) begin
        y_d  = D[k*n +: n];
        G[k] = load;
      end
    end
  end

  // Output register: load on grant, drop valid on an empty accept, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sy_q  <= '0;
      vy_q  <= 1'b0;
      ptr_q <= SW'(CH - 1);
    end else if (accept) begin
      if (cand_ok) begin
        y_q  <= y_d;
        sy_q <= cand_idx;
        vy_q <= 1'b1;
        if (MODE) begin
          ptr_q <= cand_idx;
        end
      end else begin
        vy_q <= 1'b0;
      end
    end
  end

  assign Y  = y_q;
  assign VY = vy_q;
  assign SY = sy_q;

`ifdef MUXN_ARB_PARITY_EN
  logic p_q;

  // Parity follows Y: reloaded on exactly the edges that load Y.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= 1'b0;
    end else if (load) begin
      p_q <= ^y_d;
    end
  end

  assign P = p_q;
`else
  assign P = 1'b0;
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// tb/tb_muxn_arb.sv - randomized and directed bench for muxn_arb (CH=4 and CH=3 instances) against a behavioural model
module tb_muxn_arb;

`ifdef MUXN_ARB_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode_in [2];
  int          s_in    [2];
  logic [3:0]  v_in    [2];
  logic        rdy_in  [2];
  logic [31:0] dw      [2][4];

  logic [127:0] D4;
  logic [95:0]  D3;
  logic [3:0]   G4;
  logic [2:0]   G3;
  logic [31:0]  Y4, Y3;
  logic         VY4, VY3, P4, P3;
  logic [1:0]   SY4, SY3;

  assign D4 = {dw[0][3], dw[0][2], dw[0][1], dw[0][0]};
  assign D3 = {dw[1][2], dw[1][1], dw[1][0]};

  muxn_arb #(.n(32), .CH(4)) u4 (
    .clk(clk), .rst(rst), .MODE(mode_in[0]), .S(2'(s_in[0])), .D(D4), .V(v_in[0]),
    .G(G4), .Y(Y4), .VY(VY4), .SY(SY4), .READY(rdy_in[0]), .P(P4)
  );

  muxn_arb #(.n(32), .CH(3)) u3 (
    .clk(clk), .rst(rst), .MODE(mode_in[1]), .S(2'(s_in[1])), .D(D3), .V(v_in[1][2:0]),
    .G(G3), .Y(Y3), .VY(VY3), .SY(SY3), .READY(rdy_in[1]), .P(P3)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state, one slot per instance (0: CH=4, 1: CH=3).
  logic [31:0] m_y   [2] = '{32'h0, 32'h0};
  int          m_sy  [2] = '{0, 0};
  bit          m_vy  [2] = '{1'b0, 1'b0};
  int          m_ptr [2] = '{3, 2};
  bit          m_p   [2] = '{1'b0, 1'b0};
  int          eg_s  [2];

  function automatic int chn(input int x);
    return (x == 0) ? 4 : 3;
  endfunction

  // Which channel must be granted now, or -1.
  function automatic int exp_grant(input int x);
    int ch;
    ch = chn(x);
    if (rst) return -1;
    if (m_vy[x] && !rdy_in[x]) return -1;
    if (!mode_in[x]) return (s_in[x] < ch && v_in[x][s_in[x]]) ? s_in[x] : -1;
    for (int i = 1; i <= ch; i++) begin
      if (v_in[x][(m_ptr[x] + i) % ch]) return (m_ptr[x] + i) % ch;
    end
    return -1;
  endfunction

  // Per-cycle compare against the model, then model update at the edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int x = 0; x < 2; x++) begin
        eg_s[x] = exp_grant(x);
      end
      chk("u4.G",  G4,  (eg_s[0] < 0) ? 64'd0 : (64'd1 << eg_s[0]));
      chk("u4.VY", VY4, m_vy[0]);
      chk("u4.Y",  Y4,  m_y[0]);
      chk("u4.SY", SY4, m_sy[0]);
      chk("u4.P",  P4,  m_p[0]);
      chk("u3.G",  G3,  (eg_s[1] < 0) ? 64'd0 : (64'd1 << eg_s[1]));
      chk("u3.VY", VY3, m_vy[1]);
      chk("u3.Y",  Y3,  m_y[1]);
      chk("u3.SY", SY3, m_sy[1]);
      chk("u3.P",  P3,  m_p[1]);
      @(posedge clk);
      for (int x = 0; x < 2; x++) begin
        if (rst) begin
          m_y[x] = 0; m_sy[x] = 0; m_vy[x] = 0; m_ptr[x] = chn(x) - 1; m_p[x] = 0;
        end else if (!m_vy[x] || rdy_in[x]) begin
          if (eg_s[x] >= 0) begin
            m_y[x]  = dw[x][eg_s[x]];
            m_sy[x] = eg_s[x];
            m_vy[x] = 1'b1;
            m_p[x]  = PAR ? ^dw[x][eg_s[x]] : 1'b0;
            if (mode_in[x]) m_ptr[x] = eg_s[x];
          end else begin
            m_vy[x] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios with hand-computed literals, then randomized traffic.
  initial begin
    rst = 1'b1;
    for (int x = 0; x < 2; x++) begin
      mode_in[x] = 1'b0; s_in[x] = 0; v_in[x] = 4'b0000; rdy_in[x] = 1'b1;
      for (int k = 0; k < 4; k++) dw[x][k] = 32'h0;
    end
    s_in[0] = 1; v_in[0] = 4'b0010; dw[0][1] = 32'h00000001;
    tick();
    chk("rst.G", G4, 4'b0000);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst.VY", VY4, 1'b0);
    chk("post_rst.Y", Y4, 32'h0);
    chk("direct.G", G4, 4'b0010);
    tick();
    chk("direct.Y", Y4, 32'h00000001);
    chk("direct.SY", SY4, 2'd1);
    chk("direct.VY", VY4, 1'b1);

    mode_in[0] = 1'b1; v_in[0] = 4'b1111;
    for (int k = 0; k < 4; k++) dw[0][k] = 32'h80000000 | k;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr.SY%0d", i), SY4, i % 4);
      chk($sformatf("rr.Y%0d", i), Y4, 32'h80000000 | (i % 4));
      chk($sformatf("rr.VY%0d", i), VY4, 1'b1);
    end

    v_in[0] = 4'b0101;
    mode_in[1] = 1'b0; s_in[1] = 0; v_in[1] = 4'b0001;
    tick();
    chk("bp.first.SY", SY4, 2'd0);
    chk("bp.first.Y", Y4, 32'h80000000);
    chk("u3.load.VY", VY3, 1'b1);
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.G", G4, 4'b0000);
      tick();
      chk("bp.Y", Y4, 32'h80000000);
      chk("bp.SY", SY4, 2'd0);
      chk("bp.VY", VY4, 1'b1);
    end
    rdy_in[0] = 1'b1;
    #1;
    chk("bp.release.G", G4, 4'b0100);
    tick();
    chk("bp.release.SY", SY4, 2'd2);

    mode_in[0] = 1'b0; s_in[0] = 2; v_in[0] = 4'b1011;
    s_in[1] = 3; v_in[1] = 4'b0111;
    #1;
    chk("inv.G", G4, 4'b0000);
    chk("oor.G", G3, 3'b000);
    tick();
    chk("inv.VY", VY4, 1'b0);
    chk("oor.VY", VY3, 1'b0);

    mode_in[0] = 1'b1; v_in[0] = 4'b0010; rdy_in[0] = 1'b0;
    tick();
    chk("rst_stall.load.SY", SY4, 2'd1);
    v_in[0] = 4'b1111;
    tick();
    chk("rst_stall.hold.VY", VY4, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_stall.G", G4, 4'b0000);
    tick();
    rst = 1'b0;
    chk("rst_stall.VY", VY4, 1'b0);
    chk("rst_stall.Y", Y4, 32'h0);
    rdy_in[0] = 1'b1;
    #1;
    chk("rst_stall.next.G", G4, 4'b0001);
    tick();
    chk("rst_stall.next.SY", SY4, 2'd0);

    mode_in[0] = 1'b0; s_in[0] = 0; v_in[0] = 4'b0001; dw[0][0] = 32'h80000001;
    tick();
    chk("par.Y0", Y4, 32'h80000001);
    chk("par.P0", P4, 1'b0);
    dw[0][0] = 32'h00000001;
    tick();
    chk("par.Y1", Y4, 32'h00000001);
    chk("par.P1", P4, PAR);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(0, 15) == 0) mode_in[x] = ~mode_in[x];
        s_in[x]   = $urandom_range(0, 3);
        v_in[x]   = 4'($urandom);
        rdy_in[x] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) dw[x][k] = $urandom;
      end
      tick();
    end
    rst = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
